hwpe_stream_deserialize_buf: RTL

Splits one HWPE-Stream input into NB_OUT_STREAMS output streams in the time dimension: beat k goes to output lane (start + k) mod NB_OUT_STREAMS, round-robin. It is the receiving end paired with hwpe_stream_serialize and uses the same ctrl_serdes_t control. Each output lane has a one-entry register buffer, so a stalled lane does not combinationally couple back to the input while it has room. It sits between a streamer source and parallel datapath consumers.

---
 rtl/hwpe_stream_deserialize_buf.sv | 90 +++++++++
 1 files changed

// File: rtl/hwpe_stream_deserialize_buf.sv
// Round-robin deserializer: each input beat goes to the next output lane.
// Every output lane holds one registered beat, so lane outputs are flop-driven.
module hwpe_stream_deserialize_buf #(
    parameter int unsigned NB_OUT_STREAMS = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
    localparam int unsigned CNT_WIDTH     = $clog2(NB_OUT_STREAMS)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        clear_i,
    input  logic                                        ctrl_clear_serdes_state_i,
    input  logic [9:0]                                  ctrl_first_stream_i,
    input  logic                                        push_valid_i,
    output logic                                        push_ready_o,
    input  logic [DATA_WIDTH-1:0]                       push_data_i,
    input  logic [STRB_WIDTH-1:0]                       push_strb_i,
    output logic [NB_OUT_STREAMS-1:0]                   pop_valid_o,
    input  logic [NB_OUT_STREAMS-1:0]                   pop_ready_i,
    output logic [NB_OUT_STREAMS-1:0][DATA_WIDTH-1:0]   pop_data_o,
    output logic [NB_OUT_STREAMS-1:0][STRB_WIDTH-1:0]   pop_strb_o,
    output logic [CNT_WIDTH-1:0]                        dbg_cnt_o
);

    // Handshakes: a beat transfers on a rising clock edge where valid and ready
    // are both high; valid, once raised, holds with stable payload until then.

    localparam logic [9:0]           NB_L     = 10'(NB_OUT_STREAMS);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NB_OUT_STREAMS - 1);

    logic [CNT_WIDTH-1:0]                      cnt_q, cnt_d;
    logic [NB_OUT_STREAMS-1:0]                 buf_valid_q, buf_valid_d;
    logic [NB_OUT_STREAMS-1:0][DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [NB_OUT_STREAMS-1:0][STRB_WIDTH-1:0] buf_strb_q, buf_strb_d;
    logic                                      push_ready;
    logic                                      push_hs;

    always_comb begin
        // The selected lane accepts when empty or when it is emptying this cycle.
        push_ready  = ~buf_valid_q[cnt_q] | pop_ready_i[cnt_q];
        push_hs     = push_valid_i & push_ready;

        buf_valid_d = buf_valid_q & ~pop_ready_i;
        buf_data_d  = buf_data_q;
        buf_strb_d  = buf_strb_q;
        cnt_d       = cnt_q;

        if (push_hs) begin
            buf_valid_d[cnt_q] = 1'b1;
            buf_data_d[cnt_q]  = push_data_i;
            buf_strb_d[cnt_q]  = push_strb_i;
            if (ctrl_clear_serdes_state_i) begin
                // An out-of-range first lane falls back to lane 0.
                cnt_d = (ctrl_first_stream_i >= NB_L) ? '0
                                                      : ctrl_first_stream_i[CNT_WIDTH-1:0];
            end else if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end

        // Clear wins over everything, including a beat accepted in the same cycle.
        if (clear_i) begin
            cnt_d       = '0;
            buf_valid_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            buf_valid_q <= '0;
            buf_data_q  <= '0;
            buf_strb_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            buf_strb_q  <= buf_strb_d;
        end
    end

    assign push_ready_o = push_ready;
    assign pop_valid_o  = buf_valid_q;
    assign pop_data_o   = buf_data_q;
    assign pop_strb_o   = buf_strb_q;
    assign dbg_cnt_o    = cnt_q;

endmodule
